mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the single main-memory port between the instruction-cache miss path
// and the data-cache miss/write-through path. One requester is served at a
// time; simultaneous requests alternate (round-robin on last_grant). The
// winning request is latched, presented on the memory port until memory
// signals ready, and then a one-cycle acknowledge with read data is returned
// to the winner. A watchdog aborts a request that memory never accepts and
// reports it through err_o alongside the acknowledge.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   ic_req_i/ic_addr_i  instruction-cache read request (level, held until ack)
//   ic_ack_o/ic_rdata_o one-cycle completion pulse, read data valid with it
//   dc_req_i, dc_we_i, dc_byte_op_i, dc_addr_i, dc_wdata_i
//                       data-cache request (level, held until ack)
//   dc_ack_o/dc_rdata_o one-cycle completion pulse, read data valid with it
//   err_o               high with the ack pulse when the request timed out
//   mem_req_o, mem_we_o, mem_byte_op_o, mem_addr_o, mem_wdata_o
//                       memory request, driven only while a request is open
//   mem_ready_i/mem_rdata_i  memory accepted/completed, data valid with ready
//   busy_o              high whenever the arbiter is not idle
//
// Parameters:
//   width           address and data width in bits
//   timeout_cycles  cycles to wait for mem_ready_i before aborting (1..255)

module mem_port_arbiter #(
    parameter int width          = 32,
    parameter int timeout_cycles = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ic_req_i,
    input  logic [width-1:0] ic_addr_i,
    output logic             ic_ack_o,
    output logic [width-1:0] ic_rdata_o,
    input  logic             dc_req_i,
    input  logic             dc_we_i,
    input  logic             dc_byte_op_i,
    input  logic [width-1:0] dc_addr_i,
    input  logic [width-1:0] dc_wdata_i,
    output logic             dc_ack_o,
    output logic [width-1:0] dc_rdata_o,
    output logic             err_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             mem_byte_op_o,
    output logic [width-1:0] mem_addr_o,
    output logic [width-1:0] mem_wdata_o,
    input  logic             mem_ready_i,
    input  logic [width-1:0] mem_rdata_i,
    output logic             busy_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic OWNER_IC = 1'b0;
    localparam logic OWNER_DC = 1'b1;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(timeout_cycles);

    logic [1:0]       state;
    logic             owner;
    logic             last_grant;
    logic             lat_we;
    logic             lat_byte_op;
    logic             err_q;
    logic [width-1:0] lat_addr;
    logic [width-1:0] lat_wdata;
    logic [width-1:0] ic_rdata_q;
    logic [width-1:0] dc_rdata_q;
    logic [7:0]       wait_cnt;
    logic [7:0]       cnt_next;
    logic             timed_out;
    logic             grant_any;
    logic             grant_dc;
    logic             in_req;
    logic             in_resp;

    // DC wins when it is the only requester, or on a tie when IC was served last.
    always_comb begin
        grant_any = ic_req_i | dc_req_i;
        grant_dc  = dc_req_i & (~ic_req_i | (last_grant == OWNER_IC));
    end

    // Saturating count of unanswered REQ cycles; the abort fires on the
    // cycle whose count would reach the limit, so REQ lasts exactly
    // timeout_cycles cycles when memory never answers.
    always_comb begin
        cnt_next  = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
        timed_out = (cnt_next >= TIMEOUT_LIMIT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            owner       <= OWNER_IC;
            last_grant  <= OWNER_IC;
            lat_we      <= 1'b0;
            lat_byte_op <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            err_q       <= 1'b0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
            wait_cnt    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner      <= grant_dc;
                        last_grant <= grant_dc;
                        lat_addr   <= grant_dc ? dc_addr_i : ic_addr_i;
                        // Instruction fetches are always full-word reads.
                        lat_we      <= grant_dc & dc_we_i;
                        lat_byte_op <= grant_dc & dc_byte_op_i;
                        lat_wdata   <= grant_dc ? dc_wdata_i : '0;
                        wait_cnt    <= 8'd0;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ready_i) begin
                        if (owner == OWNER_DC) begin
                            dc_rdata_q <= mem_rdata_i;
                        end else begin
                            ic_rdata_q <= mem_rdata_i;
                        end
                        err_q <= 1'b0;
                        state <= RESP;
                    end else begin
                        wait_cnt <= cnt_next;
                        if (timed_out) begin
                            if (owner == OWNER_DC) begin
                                dc_rdata_q <= '0;
                            end else begin
                                ic_rdata_q <= '0;
                            end
                            err_q <= 1'b1;
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The memory port is quiet outside REQ so stale latched values never
    // reach memory while the arbiter is idle or acknowledging.
    always_comb begin
        in_req        = (state == REQ);
        in_resp       = (state == RESP);
        mem_req_o     = in_req;
        mem_we_o      = in_req & lat_we;
        mem_byte_op_o = in_req & lat_byte_op;
        mem_addr_o    = in_req ? lat_addr : '0;
        mem_wdata_o   = in_req ? lat_wdata : '0;
        ic_ack_o      = in_resp & (owner == OWNER_IC);
        dc_ack_o      = in_resp & (owner == OWNER_DC);
        err_o         = in_resp & err_q;
        ic_rdata_o    = ic_rdata_q;
        dc_rdata_o    = dc_rdata_q;
        busy_o        = (state != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. Two instances share one set of
// stimulus: the main instance (short watchdog so random traffic also hits
// aborts) and a second one with timeout_cycles = 4 for the directed timeout
// sequence. Inputs change just after the falling edge; outputs are compared
// on the falling edge, half a cycle away from the sampling edge.

module tb_mem_port_arbiter;

    localparam int MAIN_TO = 6;
    localparam int RAND_CYCLES = 800;

    logic        clk;
    logic        rst;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        dc_req;
    logic        dc_we;
    logic        dc_byte_op;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        ic_ack, dc_ack, err, mem_req, mem_we, mem_byte_op, busy;
    logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;

    logic        t_ic_ack, t_dc_ack, t_err, t_mem_req, t_mem_we, t_mem_byte_op, t_busy;
    logic [31:0] t_ic_rdata, t_dc_rdata, t_mem_addr, t_mem_wdata;

    int tests_run;
    int tests_failed;

    mem_port_arbiter #(.width(32), .timeout_cycles(MAIN_TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_ack_o(ic_ack), .ic_rdata_o(ic_rdata),
        .dc_req_i(dc_req), .dc_we_i(dc_we), .dc_byte_op_i(dc_byte_op),
        .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata), .dc_ack_o(dc_ack), .dc_rdata_o(dc_rdata),
        .err_o(err), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_byte_op_o(mem_byte_op),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    mem_port_arbiter #(.width(32), .timeout_cycles(4)) dut_to4 (
        .clk_i(clk), .rst_i(rst),
        .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_ack_o(t_ic_ack), .ic_rdata_o(t_ic_rdata),
        .dc_req_i(dc_req), .dc_we_i(dc_we), .dc_byte_op_i(dc_byte_op),
        .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata), .dc_ack_o(t_dc_ack), .dc_rdata_o(t_dc_rdata),
        .err_o(t_err), .mem_req_o(t_mem_req), .mem_we_o(t_mem_we), .mem_byte_op_o(t_mem_byte_op),
        .mem_addr_o(t_mem_addr), .mem_wdata_o(t_mem_wdata),
        .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata), .busy_o(t_busy)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the flow above stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] global timeout");
    end

    // One cycle-by-cycle vector: inputs applied for a cycle, outputs expected
    // after the following rising edge.
    typedef struct {
        logic        rst;
        logic        ic_req;
        logic        dc_req;
        logic        ready;
        logic [31:0] rdata;
        logic        e_mem_req;
        logic [31:0] e_addr;
        logic        e_ic_ack;
        logic        e_dc_ack;
        logic [31:0] e_ic_rdata;
        logic [31:0] e_dc_rdata;
        logic        e_busy;
    } vec_t;

    vec_t vecs[15];

    // Transaction-level reference model state: the request currently open
    // on the memory port and the response waiting to be acknowledged.
    typedef struct {
        bit          valid;
        bit          is_dc;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          we;
        bit          byte_op;
        int          misses;
    } txn_t;

    typedef struct {
        bit valid;
        bit is_dc;
        bit err;
    } resp_t;

    txn_t        m_open;
    resp_t       m_resp;
    bit          m_last_was_dc;
    logic [31:0] m_ic_rd;
    logic [31:0] m_dc_rd;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        ic_req    = v.ic_req;
        dc_req    = v.dc_req;
        mem_ready = v.ready;
        mem_rdata = v.rdata;
        if (v.rst) pulseReset();
    endtask

    task automatic modelReset();
        m_open        = '{default: 0};
        m_resp        = '{default: 0};
        m_last_was_dc = 1'b0;
        m_ic_rd       = 32'h0;
        m_dc_rd       = 32'h0;
    endtask

    // Advances the model by one clock using the inputs the DUT just sampled.
    task automatic modelStep();
        if (m_resp.valid) begin
            m_resp.valid = 1'b0;
        end else if (m_open.valid) begin
            if (mem_ready) begin
                if (m_open.is_dc) m_dc_rd = mem_rdata; else m_ic_rd = mem_rdata;
                m_resp = '{valid: 1'b1, is_dc: m_open.is_dc, err: 1'b0};
                m_open.valid = 1'b0;
            end else begin
                m_open.misses++;
                if (m_open.misses >= MAIN_TO) begin
                    if (m_open.is_dc) m_dc_rd = 32'h0; else m_ic_rd = 32'h0;
                    m_resp = '{valid: 1'b1, is_dc: m_open.is_dc, err: 1'b1};
                    m_open.valid = 1'b0;
                end
            end
        end else if (ic_req || dc_req) begin
            bit pick_dc;
            pick_dc = (ic_req && dc_req) ? !m_last_was_dc : dc_req;
            m_last_was_dc = pick_dc;
            m_open.valid   = 1'b1;
            m_open.is_dc   = pick_dc;
            m_open.addr    = pick_dc ? dc_addr : ic_addr;
            m_open.wdata   = dc_wdata;
            m_open.we      = pick_dc && dc_we;
            m_open.byte_op = pick_dc && dc_byte_op;
            m_open.misses  = 0;
        end
    endtask

    task automatic modelCompare(input int cyc);
        checkOutput($sformatf("rnd%0d mem_req", cyc), mem_req, m_open.valid);
        if (m_open.valid) begin
            checkOutput($sformatf("rnd%0d mem_addr", cyc), mem_addr, m_open.addr);
            checkOutput($sformatf("rnd%0d mem_we", cyc), mem_we, m_open.we);
            checkOutput($sformatf("rnd%0d mem_byte_op", cyc), mem_byte_op, m_open.byte_op);
            if (m_open.is_dc)
                checkOutput($sformatf("rnd%0d mem_wdata", cyc), mem_wdata, m_open.wdata);
        end
        checkOutput($sformatf("rnd%0d ic_ack", cyc), ic_ack, m_resp.valid && !m_resp.is_dc);
        checkOutput($sformatf("rnd%0d dc_ack", cyc), dc_ack, m_resp.valid && m_resp.is_dc);
        checkOutput($sformatf("rnd%0d err", cyc), err, m_resp.valid && m_resp.err);
        checkOutput($sformatf("rnd%0d ic_rdata", cyc), ic_rdata, m_ic_rd);
        checkOutput($sformatf("rnd%0d dc_rdata", cyc), dc_rdata, m_dc_rd);
        checkOutput($sformatf("rnd%0d busy", cyc), busy, m_open.valid || m_resp.valid);
    endtask

    // Main test flow: vector table, directed multi-cycle sequences, then
    // randomized traffic against the reference model.
    initial begin
        int req_cycles;
        int to_cycles;

        tests_run    = 0;
        tests_failed = 0;
        rst        = 1'b1;
        ic_req     = 1'b0;
        ic_addr    = 32'h0000_0040;
        dc_req     = 1'b0;
        dc_we      = 1'b0;
        dc_byte_op = 1'b0;
        dc_addr    = 32'h0000_0100;
        dc_wdata   = 32'h0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h0;

        // Single IC read, then the tie sequence DC, IC, DC, IC from reset.
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        1'b1, 32'h40,  1'b0, 1'b0, 32'h0,        32'h0,        1'b1};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,   1'b1, 1'b0, 32'hDEADBEEF, 32'h0,        1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 32'h0,   1'b0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hAAAA0004, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA0005, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,        32'hAAAA0005, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA0006, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        32'hAAAA0005, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA0007, 1'b1, 32'h40,  1'b0, 1'b0, 32'h0,        32'hAAAA0005, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA0008, 1'b0, 32'h0,   1'b1, 1'b0, 32'hAAAA0008, 32'hAAAA0005, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA0009, 1'b0, 32'h0,   1'b0, 1'b0, 32'hAAAA0008, 32'hAAAA0005, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA000A, 1'b1, 32'h100, 1'b0, 1'b0, 32'hAAAA0008, 32'hAAAA0005, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA000B, 1'b0, 32'h0,   1'b0, 1'b1, 32'hAAAA0008, 32'hAAAA000B, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA000C, 1'b0, 32'h0,   1'b0, 1'b0, 32'hAAAA0008, 32'hAAAA000B, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA000D, 1'b1, 32'h40,  1'b0, 1'b0, 32'hAAAA0008, 32'hAAAA000B, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA000E, 1'b0, 32'h0,   1'b1, 1'b0, 32'hAAAA000E, 32'hAAAA000B, 1'b1};

        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            stepCycle();
            checkOutput($sformatf("vec%0d mem_req", i), mem_req, vecs[i].e_mem_req);
            if (vecs[i].e_mem_req) begin
                checkOutput($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_addr);
                checkOutput($sformatf("vec%0d mem_we", i), mem_we, 1'b0);
            end
            checkOutput($sformatf("vec%0d ic_ack", i), ic_ack, vecs[i].e_ic_ack);
            checkOutput($sformatf("vec%0d dc_ack", i), dc_ack, vecs[i].e_dc_ack);
            checkOutput($sformatf("vec%0d ic_rdata", i), ic_rdata, vecs[i].e_ic_rdata);
            checkOutput($sformatf("vec%0d dc_rdata", i), dc_rdata, vecs[i].e_dc_rdata);
            checkOutput($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
            checkOutput($sformatf("vec%0d err", i), err, 1'b0);
        end

        // Reset while acknowledging with both rdata registers loaded: every
        // output must clear at once, without a clock edge.
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        checkOutput("rst ic_ack", ic_ack, 1'b0);
        checkOutput("rst dc_ack", dc_ack, 1'b0);
        checkOutput("rst ic_rdata", ic_rdata, 32'h0);
        checkOutput("rst dc_rdata", dc_rdata, 32'h0);
        checkOutput("rst err", err, 1'b0);
        checkOutput("rst mem_req", mem_req, 1'b0);
        checkOutput("rst mem_we", mem_we, 1'b0);
        checkOutput("rst mem_byte_op", mem_byte_op, 1'b0);
        checkOutput("rst mem_addr", mem_addr, 32'h0);
        checkOutput("rst mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst busy", busy, 1'b0);

        // DC byte write with four wait states; address/data change mid-REQ.
        ic_req     = 1'b0;
        dc_req     = 1'b1;
        dc_we      = 1'b1;
        dc_byte_op = 1'b1;
        dc_addr    = 32'h0000_0100;
        dc_wdata   = 32'h0000_00AB;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h5555_0000;
        #1;
        rst = 1'b0;
        stepCycle();
        req_cycles = 0;
        for (int k = 1; k <= 5; k++) begin
            checkOutput($sformatf("dcw%0d mem_req", k), mem_req, 1'b1);
            checkOutput($sformatf("dcw%0d mem_we", k), mem_we, 1'b1);
            checkOutput($sformatf("dcw%0d mem_byte_op", k), mem_byte_op, 1'b1);
            checkOutput($sformatf("dcw%0d mem_addr", k), mem_addr, 32'h100);
            checkOutput($sformatf("dcw%0d mem_wdata", k), mem_wdata, 32'hAB);
            checkOutput($sformatf("dcw%0d dc_ack", k), dc_ack, 1'b0);
            if (mem_req === 1'b1) req_cycles++;
            if (k == 2) begin
                dc_addr    = 32'h0000_0200;
                dc_wdata   = 32'h0000_00CD;
                dc_byte_op = 1'b0;
                dc_we      = 1'b0;
            end
            mem_ready = (k == 5);
            stepCycle();
        end
        checkOutput("dcw req_cycles", req_cycles, 5);
        checkOutput("dcw ack", dc_ack, 1'b1);
        checkOutput("dcw ic_ack", ic_ack, 1'b0);
        checkOutput("dcw err", err, 1'b0);
        checkOutput("dcw dc_rdata", dc_rdata, 32'h5555_0000);
        checkOutput("dcw resp mem_req", mem_req, 1'b0);
        dc_req    = 1'b0;
        mem_ready = 1'b0;
        stepCycle();
        checkOutput("dcw after ack", dc_ack, 1'b0);
        checkOutput("dcw after busy", busy, 1'b0);

        // Watchdog on the timeout_cycles = 4 instance: a good read first so
        // the abort's zeroing of rdata is visible.
        pulseReset();
        ic_req    = 1'b1;
        ic_addr   = 32'h0000_0080;
        dc_req    = 1'b0;
        mem_ready = 1'b0;
        stepCycle();
        checkOutput("to4 first mem_addr", t_mem_addr, 32'h80);
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        stepCycle();
        checkOutput("to4 first ack", t_ic_ack, 1'b1);
        checkOutput("to4 first rdata", t_ic_rdata, 32'hCAFE_F00D);
        checkOutput("to4 first err", t_err, 1'b0);
        mem_ready = 1'b0;
        stepCycle();
        checkOutput("to4 idle busy", t_busy, 1'b0);
        stepCycle();
        to_cycles = 0;
        while (t_mem_req === 1'b1 && to_cycles < 20) begin
            checkOutput($sformatf("to4 req%0d ack", to_cycles), t_ic_ack, 1'b0);
            checkOutput($sformatf("to4 req%0d we", to_cycles), t_mem_we, 1'b0);
            checkOutput($sformatf("to4 req%0d byte", to_cycles), t_mem_byte_op, 1'b0);
            to_cycles++;
            stepCycle();
        end
        checkOutput("to4 req_cycles", to_cycles, 4);
        checkOutput("to4 ack", t_ic_ack, 1'b1);
        checkOutput("to4 err", t_err, 1'b1);
        checkOutput("to4 rdata", t_ic_rdata, 32'h0);
        checkOutput("to4 dc_ack", t_dc_ack, 1'b0);
        checkOutput("to4 dc_rdata", t_dc_rdata, 32'h0);
        ic_req = 1'b0;
        stepCycle();
        checkOutput("to4 end busy", t_busy, 1'b0);
        checkOutput("to4 end err", t_err, 1'b0);

        // Asynchronous reset in the middle of REQ, then a fresh tie.
        pulseReset();
        ic_addr   = 32'h0000_0040;
        dc_addr   = 32'h0000_0100;
        dc_we     = 1'b0;
        ic_req    = 1'b1;
        dc_req    = 1'b1;
        mem_ready = 1'b0;
        stepCycle();
        checkOutput("arst pre mem_req", mem_req, 1'b1);
        checkOutput("arst pre mem_addr", mem_addr, 32'h100);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst mem_req", mem_req, 1'b0);
        checkOutput("arst busy", busy, 1'b0);
        checkOutput("arst dc_ack", dc_ack, 1'b0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("arst regrant mem_req", mem_req, 1'b1);
        checkOutput("arst regrant mem_addr", mem_addr, 32'h100);
        checkOutput("arst regrant ic_ack", ic_ack, 1'b0);
        checkOutput("arst regrant dc_ack", dc_ack, 1'b0);
        mem_ready = 1'b1;
        mem_rdata = 32'h0BAD_CAFE;
        stepCycle();
        checkOutput("arst ack", dc_ack, 1'b1);
        checkOutput("arst rdata", dc_rdata, 32'h0BAD_CAFE);
        ic_req    = 1'b0;
        dc_req    = 1'b0;
        mem_ready = 1'b0;
        stepCycle();

        // Randomized traffic against the transaction-level model.
        pulseReset();
        modelReset();
        for (int c = 0; c < RAND_CYCLES; c++) begin
            modelCompare(c);
            ic_req     = ($urandom_range(0, 99) < 50);
            dc_req     = ($urandom_range(0, 99) < 50);
            dc_we      = $urandom_range(0, 1) == 1;
            dc_byte_op = $urandom_range(0, 1) == 1;
            ic_addr    = $urandom;
            dc_addr    = $urandom;
            dc_wdata   = $urandom;
            mem_ready  = ($urandom_range(0, 99) < 35);
            mem_rdata  = $urandom;
            @(posedge clk);
            modelStep();
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
